pwr_seq: RTL
============

PWR_SEQ -- requirements
Module: pwr_seq

Interface
REQ-001 SHALL have parameter RETRY_MAX, default 3: maximum automatic re-enables after an overcurrent fuse trip (range 0..3).
REQ-002 SHALL have port clk_i  input  1  single clock; all state changes on rising edge.
REQ-003 SHALL have port rst_n_i  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port start_i  input  1  single-cycle request to run the power-on sequence.
REQ-005 SHALL have port stop_i  input  1  single-cycle request to power off and return to idle.
REQ-006 SHALL have port cfg_thra_i  input  12  analog-rail overcurrent threshold.
REQ-007 SHALL have port cfg_thrd_i  input  12  digital-rail overcurrent threshold.
REQ-008 SHALL have port cfg_delay_i  input  16  overcurrent persistence delay, in cycles.
REQ-009 SHALL have port cfg_backoff_i  input  16  wait between fuse trip and retry, in cycles.
REQ-010 SHALL have port m_we_o  output  1  power-block register write enable.
REQ-011 SHALL have port m_addr_o  output  8  power-block register address.
REQ-012 SHALL have port m_data_o  output  16  power-block register write data.
REQ-013 SHALL have port m_data_i  input  16  power-block read data (combinational from m_addr_o); bit0=LDO enabled, bit1=fuse.
REQ-014 SHALL have port busy_o  output  1  sequence active (state not IDLE or FAIL).
REQ-015 SHALL have port on_o  output  1  LDO confirmed on.
REQ-016 SHALL have port failed_o  output  1  retries exhausted.
REQ-017 SHALL have port retry_cnt_o  output  2  retries used in the current run.

Function
REQ-018 SHALL implement states IDLE, WR_THRA, WR_THRD, WR_DELAY, WR_ON, MON, BACKOFF, WR_OFF, FAIL.
REQ-019 SHALL register cfg_* into internal registers on an accepted start_i; later cfg_* changes have no effect until the next start.
REQ-020 SHALL accept start_i only in IDLE or FAIL; the accepting edge clears failed_o and retry_cnt_o and enters WR_THRA.
REQ-021 SHALL spend exactly one cycle in each WR_* state with m_we_o=1: WR_THRA addr 0x03 data {4'b0,thra}; WR_THRD 0x04 {4'b0,thrd}; WR_DELAY 0x05 delay; WR_ON 0x02 data 0x0001; WR_OFF 0x02 data 0x0000; transitions WR_THRA->WR_THRD->WR_DELAY->WR_ON->MON.
REQ-022 SHALL drive m_we_o=0, m_addr_o=0x00, m_data_o=0 in all non-WR states.
REQ-023 In MON, SHALL sample m_data_i each cycle; bit1=1 -> if retry_cnt<RETRY_MAX increment retry_cnt, load backoff counter with cfg_backoff, clear on_o, go BACKOFF; else clear on_o, set failed_o, go FAIL.
REQ-024 In MON with bit1=0 and bit0=1, SHALL set on_o=1 and stay in MON; with bit1=0 and bit0=0 (switched off externally), SHALL clear on_o and go IDLE.
REQ-025 BACKOFF SHALL decrement the counter each cycle and enter WR_THRA in the cycle after it reads 0; cfg_backoff=0 gives exactly one BACKOFF cycle.
REQ-026 stop_i in any state other than IDLE, FAIL, or WR_OFF SHALL enter WR_OFF next cycle, then IDLE, with on_o cleared on WR_OFF entry; retry_cnt_o keeps its value.
REQ-027 stop_i SHALL take priority over a same-cycle fuse in MON and over start_i; in IDLE it is ignored; in FAIL it enters WR_OFF, leaves failed_o set, and goes to IDLE.
REQ-028 retry_cnt_o SHALL saturate at RETRY_MAX; RETRY_MAX=0 gives FAIL on the first trip.
REQ-029 Minimum start-to-MON latency SHALL be 4 cycles (4 write cycles).

Reset
REQ-030 Asserting rst_n_i low SHALL force IDLE asynchronously, including mid-sequence, with all outputs and counters 0.
REQ-031 After reset, SHALL issue no register write until start_i is accepted.

Verification
REQ-032 SHALL check: start_i with thra=0x100, thrd=0x200, delay=10 -> writes 0x03/0x0100, 0x04/0x0200, 0x05/0x000A, 0x02/0x0001 on 4 consecutive cycles; on_o=1 one cycle after MON sees bit0=1.
REQ-033 SHALL check: RETRY_MAX=3, backoff=5, fuse held -> 3 re-sequences each preceded by 6 BACKOFF cycles; 4th trip -> failed_o=1, retry_cnt_o=3, busy_o=0.
REQ-034 SHALL check: stop_i and fuse asserted in the same MON cycle -> single write 0x02/0x0000, then IDLE, failed_o=0, retry_cnt_o unchanged.
REQ-035 SHALL check: rst_n_i low during WR_THRD -> m_we_o drops immediately, no further writes after release until start_i.
REQ-036 SHALL check: start_i while busy -> ignored, and the write sequence is not restarted; start_i in FAIL -> failed_o clears and the sequence reruns.

Source files
------------

// File: rtl/pwr_seq.sv
// Power-block sequencer: programs overcurrent thresholds, enables the LDO,
// monitors the fuse and re-enables after a backoff up to RETRY_MAX times.
// state    | meaning
// IDLE     | waiting for start
// WR_THRA  | write analog threshold (0x03)
// WR_THRD  | write digital threshold (0x04)
// WR_DELAY | write persistence delay (0x05)
// WR_ON    | enable LDO (0x02 <- 1)
// MON      | watch LDO status and fuse
// BACKOFF  | wait before re-sequencing after a trip
// WR_OFF   | disable LDO (0x02 <- 0)
// FAIL     | retries exhausted
module pwr_seq #(
  parameter int unsigned RETRY_MAX = 3
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        start_i,
  input  logic        stop_i,
  input  logic [11:0] cfg_thra_i,
  input  logic [11:0] cfg_thrd_i,
  input  logic [15:0] cfg_delay_i,
  input  logic [15:0] cfg_backoff_i,
  output logic        m_we_o,
  output logic [7:0]  m_addr_o,
  output logic [15:0] m_data_o,
  input  logic [15:0] m_data_i,
  output logic        busy_o,
  output logic        on_o,
  output logic        failed_o,
  output logic [1:0]  retry_cnt_o
);

  typedef enum logic [3:0] {
    IDLE, WR_THRA, WR_THRD, WR_DELAY, WR_ON, MON, BACKOFF, WR_OFF, FAIL
  } state_t;

  localparam logic [1:0] RETRY_LIM = RETRY_MAX[1:0];

  state_t      state_q, state_d;
  logic [11:0] thra_q, thra_d;
  logic [11:0] thrd_q, thrd_d;
  logic [15:0] delay_q, delay_d;
  logic [15:0] backoff_q, backoff_d;
  logic [15:0] cnt_q, cnt_d;
  logic        on_q, on_d;
  logic        failed_q, failed_d;
  logic [1:0]  retry_q, retry_d;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q   <= IDLE;
      thra_q    <= '0;
      thrd_q    <= '0;
      delay_q   <= '0;
      backoff_q <= '0;
      cnt_q     <= '0;
      on_q      <= 1'b0;
      failed_q  <= 1'b0;
      retry_q   <= '0;
    end else begin
      state_q   <= state_d;
      thra_q    <= thra_d;
      thrd_q    <= thrd_d;
      delay_q   <= delay_d;
      backoff_q <= backoff_d;
      cnt_q     <= cnt_d;
      on_q      <= on_d;
      failed_q  <= failed_d;
      retry_q   <= retry_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    thra_d    = thra_q;
    thrd_d    = thrd_q;
    delay_d   = delay_q;
    backoff_d = backoff_q;
    cnt_d     = cnt_q;
    on_d      = on_q;
    failed_d  = failed_q;
    retry_d   = retry_q;
    m_we_o    = 1'b0;
    m_addr_o  = 8'h00;
    m_data_o  = 16'h0000;

    // Write port is a pure function of the current state, so a stop still
    // completes the write already on the bus this cycle.
    case (state_q)
      WR_THRA:  begin m_we_o = 1'b1; m_addr_o = 8'h03; m_data_o = {4'b0, thra_q}; end
      WR_THRD:  begin m_we_o = 1'b1; m_addr_o = 8'h04; m_data_o = {4'b0, thrd_q}; end
      WR_DELAY: begin m_we_o = 1'b1; m_addr_o = 8'h05; m_data_o = delay_q; end
      WR_ON:    begin m_we_o = 1'b1; m_addr_o = 8'h02; m_data_o = 16'h0001; end
      WR_OFF:   begin m_we_o = 1'b1; m_addr_o = 8'h02; m_data_o = 16'h0000; end
      default:  ;
    endcase

    if (stop_i && state_q != IDLE && state_q != WR_OFF) begin
      state_d = WR_OFF;
      on_d    = 1'b0;
    end else begin
      case (state_q)
        IDLE, FAIL: begin
          if (start_i) begin
            thra_d    = cfg_thra_i;
            thrd_d    = cfg_thrd_i;
            delay_d   = cfg_delay_i;
            backoff_d = cfg_backoff_i;
            failed_d  = 1'b0;
            retry_d   = '0;
            state_d   = WR_THRA;
          end
        end
        WR_THRA:  state_d = WR_THRD;
        WR_THRD:  state_d = WR_DELAY;
        WR_DELAY: state_d = WR_ON;
        WR_ON:    state_d = MON;
        MON: begin
          if (m_data_i[1]) begin
            on_d = 1'b0;
            if (retry_q < RETRY_LIM) begin
              retry_d = retry_q + 2'd1;
              cnt_d   = backoff_q;
              state_d = BACKOFF;
            end else begin
              failed_d = 1'b1;
              state_d  = FAIL;
            end
          end else if (m_data_i[0]) begin
            on_d = 1'b1;
          end else begin
            on_d    = 1'b0;
            state_d = IDLE;
          end
        end
        BACKOFF: begin
          if (cnt_q == 16'd0) state_d = WR_THRA;
          else                cnt_d   = cnt_q - 16'd1;
        end
        WR_OFF:  state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  assign busy_o      = (state_q != IDLE) && (state_q != FAIL);
  assign on_o        = on_q;
  assign failed_o    = failed_q;
  assign retry_cnt_o = retry_q;

endmodule
